// File: rtl/text_console_writer_pkg.sv
// text_console_pkg: shared definitions for the text console writer.
//   - control / printable character codes
//   - FSM state enum (IDLE / SCROLL / CLEAR)
//   - command classes and the classify() helper that maps a code to a class
// Optional feature macro: TEXT_CONSOLE_TAB_EN (0x09 becomes a tab command;
// otherwise it is discarded like any other non-printable code).
package text_console_pkg;

    localparam logic [7:0] CHAR_SPACE    = 8'h20;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_CR       = 8'h0D;
    localparam logic [7:0] CHAR_BS       = 8'h08;
    localparam logic [7:0] CHAR_FF       = 8'h0C;
    localparam logic [7:0] CHAR_TAB      = 8'h09;
    localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_PRINT = 3'd1,
        CMD_LF    = 3'd2,
        CMD_CR    = 3'd3,
        CMD_BS    = 3'd4,
        CMD_FF    = 3'd5,
        CMD_TAB   = 3'd6
    } cmd_t;

    function automatic cmd_t classify(input logic [7:0] code);
        cmd_t c;
        c = CMD_NONE;
        if (code >= CHAR_PRINT_LO && code <= CHAR_PRINT_HI) begin
            c = CMD_PRINT;
        end else begin
            case (code)
                CHAR_LF: c = CMD_LF;
                CHAR_CR: c = CMD_CR;
                CHAR_BS: c = CMD_BS;
                CHAR_FF: c = CMD_FF;
`ifdef TEXT_CONSOLE_TAB_EN
                CHAR_TAB: c = CMD_TAB;
`endif
                default: c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream handshake between a character source and the writer.
//   char_valid : source has a code on char_data
//   char_data  : 8-bit character code
//   char_ready : writer accepts a code this cycle
interface text_console_writer_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/text_console_writer_cursor.sv
// console_cursor: holds the cursor position and computes its next value
// from the command class of an accepted code.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   advance      : a code is being accepted this cycle
//   cmd          : command class of that code
//   col, row     : current cursor
//   needs_scroll : the command wraps past the last row (buffer must scroll)
module console_cursor
    import text_console_pkg::*;
#(
    parameter int COLUMNS  = 16,
    parameter int ROWS     = 4,
    parameter int TAB_STOP = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        advance,
    input  cmd_t                        cmd,
    output logic [$clog2(COLUMNS)-1:0]  col,
    output logic [$clog2(ROWS)-1:0]     row,
    output logic                        needs_scroll
);
    localparam int CW  = $clog2(COLUMNS);
    localparam int CW1 = CW + 1;
    localparam int RW  = $clog2(ROWS);

    logic [CW-1:0] col_next;
    logic [RW-1:0] row_next;
    logic [CW:0]   tab_col;
    logic          wrap;

    always_comb begin
        col_next     = col;
        row_next     = row;
        wrap         = 1'b0;
        needs_scroll = 1'b0;
        // next multiple of TAB_STOP (power of two): round up past the current column
        tab_col      = ({1'b0, col} | CW1'(TAB_STOP - 1)) + 1'b1;
        case (cmd)
            CMD_PRINT: begin
                if (col < CW'(COLUMNS - 1)) col_next = col + 1'b1;
                else                        wrap     = 1'b1;
            end
            CMD_LF: wrap = 1'b1;
            CMD_CR: col_next = '0;
            CMD_BS: begin
                if (col != '0) col_next = col - 1'b1;
            end
            CMD_FF: begin
                col_next = '0;
                row_next = '0;
            end
            CMD_TAB: begin
                if (tab_col >= CW1'(COLUMNS)) wrap     = 1'b1;
                else                          col_next = tab_col[CW-1:0];
            end
            default: ;
        endcase
        if (wrap) begin
            col_next = '0;
            if (row < RW'(ROWS - 1)) row_next     = row + 1'b1;
            else                     needs_scroll = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= col_next;
            row <= row_next;
        end
    end
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: writer side of the character text buffer read by the
// VGA character generator. Accepts codes over char_if, handles LF/CR/BS/FF
// (and tab when TEXT_CONSOLE_TAB_EN is defined), keeps a cursor, and scrolls
// the buffer up one row when the cursor passes the bottom.
// Ports:
//   CLK, RST_N  : clock, synchronous active-low reset
//   char_if     : valid/ready character stream (slave)
//   text_buffer : flat buffer, byte (r,c) at [(r*COLUMNS+c)*8 +: 8]
//   cursor_col, cursor_row : current cursor
//   busy        : high while scrolling or clearing
//
// state  | meaning
// IDLE   | accepting codes, writes happen at the cursor
// SCROLL | row k <= row k+1 for k<ROWS-1, last row blanked at k=ROWS-1
// CLEAR  | row k blanked each cycle
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int COLUMNS  = 16,
    parameter int ROWS     = 4,
    parameter int TAB_STOP = 4
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    text_console_writer_if.slave          char_if,
    output logic [COLUMNS*ROWS*8-1:0]     text_buffer,
    output logic [$clog2(COLUMNS)-1:0]    cursor_col,
    output logic [$clog2(ROWS)-1:0]       cursor_row,
    output logic                          busy
);
    localparam int CW = $clog2(COLUMNS);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] K_LAST = RW'(ROWS - 1);

    state_t state, state_next;
    logic [RW-1:0] k, k_next, k_plus;
    logic [ROWS-1:0][COLUMNS*8-1:0] rows_q;
    logic [CW-1:0] bs_col;
    logic          transfer;
    logic          needs_scroll;
    cmd_t          cmd;

    assign cmd                = classify(char_if.char_data);
    assign char_if.char_ready = (state == IDLE);
    assign transfer           = char_if.char_valid && (state == IDLE);
    assign busy               = (state != IDLE);
    assign k_plus             = k + 1'b1;
    assign bs_col             = cursor_col - 1'b1;
    assign text_buffer        = rows_q;

    console_cursor #(
        .COLUMNS  (COLUMNS),
        .ROWS     (ROWS),
        .TAB_STOP (TAB_STOP)
    ) u_cursor (
        .clk          (CLK),
        .rst_n        (RST_N),
        .advance      (transfer),
        .cmd          (cmd),
        .col          (cursor_col),
        .row          (cursor_row),
        .needs_scroll (needs_scroll)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    always_comb begin
        state_next = state;
        k_next     = k;
        case (state)
            IDLE: begin
                if (transfer) begin
                    if (cmd == CMD_FF) begin
                        state_next = CLEAR;
                        k_next     = '0;
                    end else if (needs_scroll) begin
                        state_next = SCROLL;
                        k_next     = '0;
                    end
                end
            end
            SCROLL, CLEAR: begin
                if (k == K_LAST) begin
                    state_next = IDLE;
                    k_next     = '0;
                end else begin
                    k_next = k_plus;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rows_q <= {ROWS*COLUMNS{CHAR_SPACE}};
        end else begin
            case (state)
                IDLE: begin
                    if (transfer && cmd == CMD_PRINT)
                        rows_q[cursor_row][{cursor_col, 3'b000} +: 8] <= char_if.char_data;
                    else if (transfer && cmd == CMD_BS && cursor_col != '0)
                        rows_q[cursor_row][{bs_col, 3'b000} +: 8] <= CHAR_SPACE;
                end
                SCROLL: begin
                    if (k == K_LAST) rows_q[k] <= {COLUMNS{CHAR_SPACE}};
                    else             rows_q[k] <= rows_q[k_plus];
                end
                CLEAR: rows_q[k] <= {COLUMNS{CHAR_SPACE}};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;
    localparam int COLS = 16;
    localparam int NROW = 4;
    localparam int NB   = COLS * NROW * 8;

    typedef struct {
        int col;
        int row;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] text_buffer;
    logic [3:0]    cursor_col;
    logic [1:0]    cursor_row;
    logic          busy;

    text_console_writer_if cif ();

    text_console_writer #(.COLUMNS(COLS), .ROWS(NROW), .TAB_STOP(4)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .char_if     (cif),
        .text_buffer (text_buffer),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   tc, tr;   // bench-side cursor for long fills

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_buf(input string nm, input logic [NB-1:0] exp);
        checks++;
        if (text_buffer !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, text_buffer, exp);
        end
    endtask

    function automatic int bget(input int r, input int c);
        return int'(text_buffer[(r*COLS+c)*8 +: 8]);
    endfunction

    // scoreboard monitor: one cursor check per accepted code
    initial begin : monitor
        logic pending;
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow got transfer expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_col", int'(cursor_col), e.col);
                    check("sb_row", int'(cursor_row), e.row);
                end
            end
            pending = rst_n && cif.char_valid && cif.char_ready;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        cif.char_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tc = 0;
        tr = 0;
    endtask

    task automatic send(input logic [7:0] code, input int ec, input int er);
        int n;
        n = 0;
        while (!cif.char_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cif.char_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
        cif.char_valid = 1'b1;
        cif.char_data  = code;
        exp_q.push_back('{ec, er});
        @(posedge clk);
        #1 cif.char_valid = 1'b0;
    endtask

    // printable fill, tracking the expected cursor
    task automatic fill(input logic [7:0] code, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (tc < COLS - 1) tc++;
            else begin
                tc = 0;
                if (tr < NROW - 1) tr++;
            end
            send(code, tc, tr);
        end
    endtask

    task automatic count_low(input string nm, input int exp);
        int n;
        n = 0;
        while (!cif.char_ready && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(nm, n, exp);
    endtask

    logic [NB-1:0] eb;
    logic [NB-1:0] spaces;

    initial begin
        spaces = {(COLS*NROW){8'h20}};
        cif.char_valid = 1'b0;
        cif.char_data  = 8'h00;
        apply_reset();

        // reset state
        check("rst_ready", int'(cif.char_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        check_buf("rst_buf", spaces);

        // back-to-back 'A','B'
        cif.char_valid = 1'b1;
        cif.char_data  = 8'h41;
        exp_q.push_back('{1, 0});
        @(posedge clk);
        #1 check("ab_ready1", int'(cif.char_ready), 1);
        cif.char_data = 8'h42;
        exp_q.push_back('{2, 0});
        @(posedge clk);
        #1 cif.char_valid = 1'b0;
        check("ab_ready2", int'(cif.char_ready), 1);
        eb = spaces;
        eb[7:0]  = 8'h41;
        eb[15:8] = 8'h42;
        check_buf("ab_buf", eb);

        // one full row, no scroll
        apply_reset();
        fill(8'h41, 16);
        check("row_busy", int'(busy), 0);
        eb = spaces;
        for (int c = 0; c < COLS; c++) eb[c*8 +: 8] = 8'h41;
        check_buf("row_buf", eb);

        // fill rows with 0x30+row, then wrap past the bottom
        apply_reset();
        for (int r = 0; r < NROW; r++) fill(8'h30 + 8'(r), (r == NROW - 1) ? COLS - 1 : COLS);
        send(8'h41, 0, 3);
        count_low("scroll_len", 4);
        eb = spaces;
        for (int c = 0; c < COLS; c++) begin
            eb[(0*COLS+c)*8 +: 8] = 8'h31;
            eb[(1*COLS+c)*8 +: 8] = 8'h32;
            eb[(2*COLS+c)*8 +: 8] = (c == COLS - 1) ? 8'h41 : 8'h33;
        end
        check_buf("scroll_buf", eb);
        check("scroll_col", int'(cursor_col), 0);
        check("scroll_row", int'(cursor_row), 3);

        // backspace / CR / discarded code
        apply_reset();
        send(8'h0A, 0, 1);
        for (int i = 1; i <= 5; i++) send(8'h43, i, 1);
        send(8'h08, 4, 1);
        check("bs_clear", bget(1, 4), 32'h20);
        check("bs_keep", bget(1, 3), 32'h43);
        send(8'h0D, 0, 1);
        send(8'h08, 0, 1);
        check("bs_col0", bget(1, 0), 32'h43);
        send(8'h07, 0, 1);

        // tab handling
        for (int i = 1; i <= 5; i++) send(8'h44, i, 1);
`ifdef TEXT_CONSOLE_TAB_EN
        send(8'h09, 8, 1);
        check("tab_nowrite", bget(1, 5), 32'h20);
        for (int i = 9; i <= 13; i++) send(8'h45, i, 1);
        send(8'h09, 0, 2);
`else
        send(8'h09, 5, 1);
        check("tab_nowrite", bget(1, 5), 32'h20);
        for (int i = 6; i <= 13; i++) send(8'h45, i, 1);
        send(8'h09, 13, 1);
`endif

        // form feed clears the buffer
        apply_reset();
        fill(8'h41, COLS * NROW - 1);
        send(8'h0C, 0, 0);
        count_low("clear_len", 4);
        check_buf("clear_buf", spaces);
        check("clear_col", int'(cursor_col), 0);
        check("clear_row", int'(cursor_row), 0);

        // reset during CLEAR
        tc = 0;
        tr = 0;
        fill(8'h41, COLS * NROW - 1);
        send(8'h0C, 0, 0);
        @(posedge clk);
        #1;
        check("clr_mid_row0", bget(0, 0), 32'h20);
        check("clr_mid_row1", bget(1, 0), 32'h41);
        check("clr_mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("abort_ready", int'(cif.char_ready), 1);
        check("abort_busy", int'(busy), 0);
        check_buf("abort_buf", spaces);

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
